// File: rtl/fib_pkg.sv
// Shared definitions for the FIB lookup pipeline: walker FSM encoding and the
// default widths that walker and tree levels must agree on.
package fib_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } walk_state_e;

    localparam int unsigned DefWordSize    = 16;
    localparam int unsigned DefPointerSize = 16;

    // Smallest level-index width that can hold 0 (no level) through num_levels.
    function automatic int unsigned level_w_for(input int unsigned num_levels);
        return (num_levels < 1) ? 1 : $clog2(num_levels + 1);
    endfunction

endpackage

// File: rtl/fib_level_walker.sv
// Lookup initiator: walks BST levels 1..NUM_LEVELS for one word at a time and
// returns hit/miss with the level and node address where the walk ended.
module fib_level_walker
    import fib_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DefWordSize,
    parameter int unsigned POINTER_SIZE = DefPointerSize,
    parameter int unsigned NUM_LEVELS   = 4,
    parameter int unsigned LEVEL_W      = 8,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [POINTER_SIZE-1:0] ROOT_ADDR = '0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    req_valid_in,
    input  logic [WORD_SIZE-1:0]    req_word_in,
    output logic                    req_ready_out,
    output logic [LEVEL_W-1:0]      lvl_sel_out,
    output logic [POINTER_SIZE-1:0] lvl_addr_out,
    output logic [WORD_SIZE-1:0]    lvl_lookup_out,
    input  logic [POINTER_SIZE-1:0] lvl_next_ptr_in,
    input  logic                    lvl_match_in,
    input  logic                    lvl_no_child_in,
    output logic                    resp_valid_out,
    output logic                    resp_hit_out,
    output logic [LEVEL_W-1:0]      resp_level_out,
    output logic [POINTER_SIZE-1:0] resp_addr_out,
    input  logic                    resp_ready_in
);

    localparam int unsigned CntW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY + 1) : 1;
    localparam logic [CntW-1:0]    CntLoad   = CntW'(RESP_LATENCY);
    localparam logic [LEVEL_W-1:0] LastLevel = LEVEL_W'(NUM_LEVELS);

    walk_state_e             state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [LEVEL_W-1:0]      sel_q, sel_d;
    logic [POINTER_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    word_q, word_d;
    logic                    hit_q, hit_d;
    logic [LEVEL_W-1:0]      rlvl_q, rlvl_d;
    logic [POINTER_SIZE-1:0] raddr_q, raddr_d;

    logic sample;
    logic walk_done;

    // Level outputs are only trusted once the latency counter has drained.
    assign sample    = (state_q == StWait) && (cnt_q == '0);
    assign walk_done = lvl_match_in || lvl_no_child_in || (sel_q == LastLevel);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid_in) state_d = StWait;
            StWait:  if (sample && walk_done) state_d = StResp;
            StResp:  if (resp_ready_in) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready_out  = (state_q == StIdle);
        resp_valid_out = (state_q == StResp);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            hit_q   <= 1'b0;
            rlvl_q  <= '0;
            raddr_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            hit_q   <= hit_d;
            rlvl_q  <= rlvl_d;
            raddr_q <= raddr_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        word_d  = word_q;
        hit_d   = hit_q;
        rlvl_d  = rlvl_q;
        raddr_d = raddr_q;
        case (state_q)
            StIdle: begin
                if (req_valid_in) begin
                    word_d = req_word_in;
                    sel_d  = LEVEL_W'(1);
                    addr_d = ROOT_ADDR;
                    cnt_d  = CntLoad;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (walk_done) begin
                    hit_d   = lvl_match_in;
                    rlvl_d  = sel_q;
                    raddr_d = addr_q;
                end else begin
                    sel_d  = sel_q + LEVEL_W'(1);
                    addr_d = lvl_next_ptr_in;
                    cnt_d  = CntLoad;
                end
            end
            StResp: begin
                if (resp_ready_in) sel_d = '0;
            end
            default: ;
        endcase
    end

    assign lvl_sel_out    = sel_q;
    assign lvl_addr_out   = addr_q;
    assign lvl_lookup_out = word_q;
    assign resp_hit_out   = hit_q;
    assign resp_level_out = rlvl_q;
    assign resp_addr_out  = raddr_q;

endmodule

// File: tb/tb_fib_level_walker.sv
// Self-checking bench: a behavioural BST tree drives the level interface and a
// whole-walk reference model predicts result and latency for each lookup.
module tb_fib_level_walker;

    localparam int unsigned NumLevels = 4;
    localparam int unsigned Nodes     = 16;
    localparam logic [15:0] RootAddr  = 16'd0;

    typedef struct packed {
        logic        match;
        logic        no_child;
        logic [15:0] ptr;
    } node_res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_word = '0;
    logic        req_ready;
    logic [7:0]  lvl_sel;
    logic [15:0] lvl_addr;
    logic [15:0] lvl_lookup;
    logic [15:0] lvl_next_ptr;
    logic        lvl_match;
    logic        lvl_no_child;
    logic        resp_valid;
    logic        resp_hit;
    logic [7:0]  resp_level;
    logic [15:0] resp_addr;
    logic        resp_ready = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] key_m   [1:NumLevels][0:Nodes-1];
    logic [15:0] left_m  [1:NumLevels][0:Nodes-1];
    logic [15:0] right_m [1:NumLevels][0:Nodes-1];
    logic        lval_m  [1:NumLevels][0:Nodes-1];
    logic        rval_m  [1:NumLevels][0:Nodes-1];

    node_res_t lvl_res_q = '0;

    always #5 clk = ~clk;

    fib_level_walker #(
        .WORD_SIZE    (16),
        .POINTER_SIZE (16),
        .NUM_LEVELS   (NumLevels),
        .LEVEL_W      (8),
        .RESP_LATENCY (1),
        .ROOT_ADDR    (RootAddr)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .req_valid_in    (req_valid),
        .req_word_in     (req_word),
        .req_ready_out   (req_ready),
        .lvl_sel_out     (lvl_sel),
        .lvl_addr_out    (lvl_addr),
        .lvl_lookup_out  (lvl_lookup),
        .lvl_next_ptr_in (lvl_next_ptr),
        .lvl_match_in    (lvl_match),
        .lvl_no_child_in (lvl_no_child),
        .resp_valid_out  (resp_valid),
        .resp_hit_out    (resp_hit),
        .resp_level_out  (resp_level),
        .resp_addr_out   (resp_addr),
        .resp_ready_in   (resp_ready)
    );

    // One BST node compare: match, else follow left (smaller) or right child.
    function automatic node_res_t eval_node(input int l, input int a, input logic [15:0] w);
        node_res_t r;
        r = '0;
        if (l < 1 || l > int'(NumLevels) || a < 0 || a >= int'(Nodes)) return r;
        if (key_m[l][a] == w) begin
            r.match = 1'b1;
        end else if (w < key_m[l][a]) begin
            r.ptr      = left_m[l][a];
            r.no_child = !lval_m[l][a];
        end else begin
            r.ptr      = right_m[l][a];
            r.no_child = !rval_m[l][a];
        end
        return r;
    endfunction

    // Tree level with one edge of response latency.
    always @(posedge clk) lvl_res_q <= eval_node(int'(lvl_sel), int'(lvl_addr), lvl_lookup);
    assign lvl_match    = lvl_res_q.match;
    assign lvl_no_child = lvl_res_q.no_child;
    assign lvl_next_ptr = lvl_res_q.ptr;

    function automatic void ref_walk(input logic [15:0] w, output bit hit, output int lvl,
                                     output int addr);
        int a;
        node_res_t r;
        a = int'(RootAddr);
        hit = 1'b0;
        lvl = 0;
        addr = 0;
        for (int l = 1; l <= int'(NumLevels); l++) begin
            r = eval_node(l, a, w);
            lvl  = l;
            addr = a;
            if (r.match) begin
                hit = 1'b1;
                return;
            end
            if (r.no_child || l == int'(NumLevels)) return;
            a = int'(r.ptr);
        end
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tree();
        for (int l = 1; l <= int'(NumLevels); l++) begin
            for (int a = 0; a < int'(Nodes); a++) begin
                key_m[l][a]   = 16'hffff;
                left_m[l][a]  = '0;
                right_m[l][a] = '0;
                lval_m[l][a]  = 1'b0;
                rval_m[l][a]  = 1'b0;
            end
        end
    endtask

    task automatic set_node(input int l, input int a, input logic [15:0] k, input logic [15:0] lp,
                            input bit lv, input logic [15:0] rp, input bit rv);
        key_m[l][a]   = k;
        left_m[l][a]  = lp;
        lval_m[l][a]  = lv;
        right_m[l][a] = rp;
        rval_m[l][a]  = rv;
    endtask

    task automatic random_tree();
        for (int l = 1; l <= int'(NumLevels); l++) begin
            for (int a = 0; a < int'(Nodes); a++) begin
                set_node(l, a, 16'($urandom_range(0, 255)),
                         16'($urandom_range(0, Nodes - 1)), ($urandom_range(0, 3) != 0),
                         16'($urandom_range(0, Nodes - 1)), ($urandom_range(0, 3) != 0));
            end
        end
    endtask

    // Entered and left on a falling edge so calls run back to back.
    task automatic run_lookup(input logic [15:0] w, input int hold, input bit noise);
        bit eh;
        int el, ea, n;
        ref_walk(w, eh, el, ea);
        check_eq("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_word  = w;
        @(negedge clk);
        req_valid = noise;
        req_word  = noise ? 16'($urandom) : w;
        check_eq("accept_busy", 32'(req_ready), 32'd0);
        check_eq("accept_sel", 32'(lvl_sel), 32'd1);
        check_eq("accept_addr", 32'(lvl_addr), 32'(RootAddr));
        check_eq("accept_word", 32'(lvl_lookup), 32'(w));
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check_eq("latency", 32'(n), 32'(2 * el));
        if (!resp_valid) return;
        check_eq("resp_hit", 32'(resp_hit), 32'(eh));
        check_eq("resp_level", 32'(resp_level), 32'(el));
        check_eq("resp_addr", 32'(resp_addr), 32'(ea));
        for (int i = 0; i < hold; i++) begin
            req_valid = (i == 1);
            req_word  = 16'($urandom);
            @(negedge clk);
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_busy", 32'(req_ready), 32'd0);
            check_eq("hold_hit", 32'(resp_hit), 32'(eh));
            check_eq("hold_level", 32'(resp_level), 32'(el));
            check_eq("hold_addr", 32'(resp_addr), 32'(ea));
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("post_valid", 32'(resp_valid), 32'd0);
        check_eq("post_sel", 32'(lvl_sel), 32'd0);
        check_eq("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, seen;
        clear_tree();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_hit", 32'(resp_hit), 32'd0);
        check_eq("rst_sel", 32'(lvl_sel), 32'd0);
        check_eq("rst_addr", 32'(lvl_addr), 32'd0);
        check_eq("rst_lookup", 32'(lvl_lookup), 32'd0);
        check_eq("rst_rlevel", 32'(resp_level), 32'd0);
        check_eq("rst_raddr", 32'(resp_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Root hit, level-2 hit via left child, miss on missing right child.
        set_node(1, 0, 16'h0050, 16'd3, 1'b1, 16'd0, 1'b0);
        set_node(2, 3, 16'h0030, 16'd5, 1'b1, 16'd6, 1'b0);
        set_node(3, 5, 16'h0020, 16'd4, 1'b1, 16'd0, 1'b0);
        run_lookup(16'h0050, 0, 1'b0);
        run_lookup(16'h0030, 0, 1'b0);
        run_lookup(16'h0070, 0, 1'b0);
        // Backpressure with an ignored request pulse, then back-to-back accept.
        run_lookup(16'h0050, 5, 1'b0);
        run_lookup(16'h0030, 1, 1'b1);

        // Every level steers right with no match: depth exhausted at the last level.
        clear_tree();
        set_node(1, 0, 16'h0010, 16'd0, 1'b0, 16'd2, 1'b1);
        set_node(2, 2, 16'h0010, 16'd0, 1'b0, 16'd7, 1'b1);
        set_node(3, 7, 16'h0010, 16'd0, 1'b0, 16'd9, 1'b1);
        set_node(4, 9, 16'h0010, 16'd0, 1'b0, 16'd1, 1'b1);
        run_lookup(16'h00ff, 2, 1'b0);

        // Reset while waiting on level 2 aborts the walk with no result.
        clear_tree();
        set_node(1, 0, 16'h0050, 16'd3, 1'b1, 16'd0, 1'b0);
        set_node(2, 3, 16'h0030, 16'd5, 1'b1, 16'd0, 1'b0);
        set_node(3, 5, 16'h0020, 16'd4, 1'b1, 16'd0, 1'b0);
        req_valid = 1'b1;
        req_word  = 16'h0010;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (lvl_sel != 8'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_reach_l2", 32'(lvl_sel), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_valid", 32'(resp_valid), 32'd0);
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        check_eq("abort_sel", 32'(lvl_sel), 32'd0);
        rst = 1'b0;
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        resp_ready = 1'b0;
        check_eq("abort_no_result", 32'(seen), 32'd0);

        // Randomized trees and lookups.
        for (int t = 0; t < 60; t++) begin
            logic [15:0] w;
            if (t % 10 == 0) random_tree();
            if ($urandom_range(0, 1) == 0)
                w = key_m[$urandom_range(1, NumLevels)][$urandom_range(0, Nodes - 1)];
            else
                w = 16'($urandom_range(0, 255));
            run_lookup(w, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fib_level_walker.md
Name: fib_level_walker

Overview:
Lookup initiator that drives the per-level BST search interface of the FIB pipeline. It accepts one lookup word and walks levels 1..NUM_LEVELS. At each level it presents a node address and the lookup word to the selected level, waits the fixed response latency, then consumes next_pointer/is_match/no_child. It reports hit (level plus node address) or miss through a valid/ready result port.

Parameters:
WORD_SIZE, 16, width of lookup word; must equal the level word width.
POINTER_SIZE, 16, width of node address/pointer.
NUM_LEVELS, 4, number of levels in the tree; legal range 1..255.
LEVEL_W, 8, width of the level index; must satisfy 2^LEVEL_W > NUM_LEVELS.
RESP_LATENCY, 1, clock edges from the address being sampled by a level to its outputs being valid; must be ≥1.
ROOT_ADDR, 0, node address used at level 1.

Ports:
clk_in  input  1  clock; all state updates on the rising edge.
rst_in  input  1  asynchronous, active-high reset.
req_valid_in  input  1  lookup request valid.
req_word_in  input  WORD_SIZE  word to search.
req_ready_out  output  1  walker can accept a request.
lvl_sel_out  output  LEVEL_W  level being addressed (1-based; 0 = none).
lvl_addr_out  output  POINTER_SIZE  node address to the level (address_in).
lvl_lookup_out  output  WORD_SIZE  compare word to the level (lookup_cont_in).
lvl_next_ptr_in  input  POINTER_SIZE  level next_pointer_out.
lvl_match_in  input  1  level is_match_out.
lvl_no_child_in  input  1  level no_child_out.
resp_valid_out  output  1  result valid.
resp_hit_out  output  1  1 = match found, 0 = miss.
resp_level_out  output  LEVEL_W  level of the match, or the last level visited on a miss.
resp_addr_out  output  POINTER_SIZE  node address of the match, or of the last node visited.
resp_ready_in  input  1  consumer accepts the result.

Behaviour:
- Reset: state IDLE; req_ready_out=1; resp_valid_out=0; resp_hit_out=0; lvl_sel_out=0; lvl_addr_out=0; lvl_lookup_out=0; resp_level_out=0; resp_addr_out=0; wait counter=0.
- Reset asserted mid-walk aborts the walk immediately. No result is produced for the aborted request.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_out=1.
  - On req_valid_in&&req_ready_out: latch the word into lvl_lookup_out, set lvl_sel_out=1 and lvl_addr_out=ROOT_ADDR, load the wait counter with RESP_LATENCY, and go to WAIT.
- WAIT:
  - lvl_sel/addr/lookup are held stable.
  - The counter decrements each cycle. When it is 0, the level inputs are sampled that cycle.
  - Evaluation priority on the sampled inputs:
    - lvl_match_in=1: hit. Record resp_level=lvl_sel, resp_addr=lvl_addr, resp_hit=1, go to RESP.
    - Else lvl_no_child_in=1: miss, same recording with resp_hit=0, go to RESP.
    - Else lvl_sel==NUM_LEVELS: miss (tree depth exhausted), go to RESP.
    - Else advance: lvl_sel+1, lvl_addr=lvl_next_ptr_in, reload the counter with RESP_LATENCY, stay in WAIT.
- Per-level cost is RESP_LATENCY+1 cycles. With RESP_LATENCY=1, a hit at level k gives resp_valid_out 2k cycles after the accepting edge.
- RESP:
  - resp_valid_out=1 and req_ready_out=0.
  - Result outputs are held until resp_valid_out&&resp_ready_in, then go to IDLE with lvl_sel_out=0.
  - A new request is accepted no earlier than the cycle after the handshake.
- Walker is single-outstanding: req_valid_in is ignored outside IDLE.
- lvl_next_ptr_in is used unmodified; no bounds check is performed on pointer values.
- Level index arithmetic is unsigned LEVEL_W bits. It never wraps because the NUM_LEVELS check terminates the walk first.

Decomposition:
- Shared package fib_pkg holds:
  - FSM state encoding (IDLE/WAIT/RESP);
  - default WORD_SIZE/POINTER_SIZE constants shared with level;
  - LEVEL_W derivation helper (clog2).
- No sub-module required.
- A bench-only wrapper, fib_level_mux, instantiates NUM_LEVELS level instances and routes their outputs by lvl_sel_out.

Test Plan:
- Reset during WAIT at level 2 -> next cycle resp_valid_out=0, req_ready_out=1, lvl_sel_out=0; no result ever produced for that request.
- Root word 0x0050, request 0x0050 -> hit at level 1, resp_level=1, resp_addr=0, resp_valid 2 cycles after accept.
- Request 0x0030: root 0x0050 gives left ptr 3; level2[3]=0x0030 -> hit, resp_level=2, resp_addr=3, valid 4 cycles after accept.
- Request 0x0070 with the root right pointer invalid (no_child=1) -> miss, resp_hit=0, resp_level=1, resp_addr=0.
- NUM_LEVELS=2 and no match on either level -> miss with resp_level=2, resp_addr equal to the level-1 next pointer.
- resp_ready_in held 0 for 5 cycles -> outputs stable, req_ready_out=0, and a req_valid_in pulse is ignored. After the handshake, a back-to-back request is accepted in the following cycle.
